// File: rtl/hms_clock.sv
// hms_clock: 24-hour hh:mm:ss counter with run enable, clear and prescaler.
// Define BCD_OUT_EN for packed-BCD outputs; otherwise outputs are binary.
module hms_clock #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       ap_clk,
  input  logic       ap_rst,
  input  logic       clear,
  input  logic       start_r,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  logic [PW-1:0] pre;
  logic [4:0] h;
  logic [5:0] m, s;
  logic tick;
  assign tick = pre == PW'(TICKS_PER_SEC - 1);
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      pre <= '0;
      h <= '0;
      m <= '0;
      s <= '0;
    end else if (clear) begin
      pre <= '0;
      h <= '0;
      m <= '0;
      s <= '0;
    end else if (start_r) begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        s <= s == 6'd59 ? 6'd0 : s + 6'd1;
        if (s == 6'd59) begin
          m <= m == 6'd59 ? 6'd0 : m + 6'd1;
          if (m == 6'd59) h <= h == 5'd23 ? 5'd0 : h + 5'd1;
        end
      end
    end
  end
`ifdef BCD_OUT_EN
  function automatic logic [7:0] enc(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction
`else
  function automatic logic [7:0] enc(input logic [5:0] v);
    return {2'b00, v};
  endfunction
`endif
  assign hh = enc({1'b0, h});
  assign mm = enc(m);
  assign ss = enc(s);
endmodule

// File: tb/tb_hms_clock.sv
// tb_hms_clock: random and directed checks of hms_clock against a seconds-of-day model.
module tb_hms_clock;
  logic ap_clk = 0, ap_rst = 1, clear = 0, clear_c = 0, start_r = 0;
  logic [7:0] hh1, mm1, ss1, hh4, mm4, ss4, hhc, mmc, ssc;
  int checks = 0, errors = 0;
  int t1 = 0, t4 = 0, p4 = 0, tc = 0;

  hms_clock #(.TICKS_PER_SEC(1)) dut1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .clear(clear), .start_r(start_r), .hh(hh1), .mm(mm1), .ss(ss1));
  hms_clock #(.TICKS_PER_SEC(4)) dut4 (.ap_clk(ap_clk), .ap_rst(ap_rst), .clear(clear), .start_r(start_r), .hh(hh4), .mm(mm4), .ss(ss4));
  hms_clock #(.TICKS_PER_SEC(1)) dutc (.ap_clk(ap_clk), .ap_rst(ap_rst), .clear(clear_c), .start_r(start_r), .hh(hhc), .mm(mmc), .ss(ssc));

  always #5 ap_clk = ~ap_clk;

  function automatic logic [7:0] enc(input int v);
`ifdef BCD_OUT_EN
    return {4'(v / 10), 4'(v % 10)};
`else
    return 8'(v);
`endif
  endfunction

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_t(input string n, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                       input int eh, input int em, input int es);
    chk({n, ".hh"}, h, enc(eh));
    chk({n, ".mm"}, m, enc(em));
    chk({n, ".ss"}, s, enc(es));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  // Model: time as seconds since midnight, plus a plain prescaler count.
  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      t1 <= 0; t4 <= 0; p4 <= 0; tc <= 0;
    end else begin
      if (clear) begin
        t1 <= 0; t4 <= 0; p4 <= 0;
      end else if (start_r) begin
        t1 <= (t1 + 1) % 86400;
        p4 <= (p4 + 1) % 4;
        if (p4 == 3) t4 <= (t4 + 1) % 86400;
      end
      if (clear_c) tc <= 0;
      else if (start_r) tc <= (tc + 1) % 86400;
    end
  end

  always @(negedge ap_clk) begin
    chk_t("model1", hh1, mm1, ss1, t1 / 3600, (t1 / 60) % 60, t1 % 60);
    chk_t("model4", hh4, mm4, ss4, t4 / 3600, (t4 / 60) % 60, t4 % 60);
    chk_t("modelc", hhc, mmc, ssc, tc / 3600, (tc / 60) % 60, tc % 60);
  end

  initial begin
    step(2);
    ap_rst = 0;
    chk_t("reset", hh1, mm1, ss1, 0, 0, 0);
    start_r = 1;
    step(61);
    chk_t("run61", hh1, mm1, ss1, 0, 1, 1);
    chk("run61_ss4", ss4, enc(15));
    @(posedge ap_clk);
    #2 ap_rst = 1;
    #1 chk_t("async_rst", hh1, mm1, ss1, 0, 0, 0);
    chk("async_rst_ss4", ss4, enc(0));
    @(negedge ap_clk);
    ap_rst = 0;
    step(10);
    chk_t("to10", hh1, mm1, ss1, 0, 0, 10);
    start_r = 0;
    step(5);
    chk_t("hold", hh1, mm1, ss1, 0, 0, 10);
    start_r = 1;
    step(1);
    chk_t("resume", hh1, mm1, ss1, 0, 0, 11);
    start_r = 0;
    clear = 1;
    step(1);
    clear = 0;
    start_r = 1;
    step(8);
    chk("tps4_8", ss4, enc(2));
    clear = 1;
    step(1);
    chk("clear_pri_ss1", ss1, enc(0));
    clear = 0;
    step(2);
    start_r = 0;
    step(3);
    chk("tps4_pause", ss4, enc(0));
    start_r = 1;
    step(2);
    chk("tps4_resume", ss4, enc(1));
    repeat (400) begin
      start_r = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 31) == 0;
      clear_c = $urandom_range(0, 15) == 0;
      step(1);
    end
    start_r = 0;
    clear = 1;
    clear_c = 1;
    step(1);
    clear = 0;
    clear_c = 0;
    start_r = 1;
    step(45296);
    chk_t("noon", hh1, mm1, ss1, 12, 34, 56);
    chk_t("noon_c", hhc, mmc, ssc, 12, 34, 56);
    clear_c = 1;
    step(1);
    chk_t("clr_run", hhc, mmc, ssc, 0, 0, 0);
    chk_t("noon_next", hh1, mm1, ss1, 12, 34, 57);
    clear_c = 0;
    step(1);
    chk_t("after_clr", hhc, mmc, ssc, 0, 0, 1);
    step(41101);
    chk_t("eod", hh1, mm1, ss1, 23, 59, 59);
    step(1);
    chk_t("midnight", hh1, mm1, ss1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
